// File: rtl/mblock_stage_sequencer.sv
// Steps the shared memory block through the four instruction stages.
// Stage 0 fetches the opcode; stages 1-3 take their block selector from it.
module mblock_stage_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       halt,
  input  logic       execute_from_brom,
  input  logic [3:0] stage_req,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [1:0] grant,
  output logic [1:0] mblock_selector,
  output logic       mem_valid,
  output logic [3:0] stage_ack,
  output logic [7:0] instruction_op,
  output logic       busy,
  output logic       timeout_err
);

  // Stage states share their low two bits with the stage index.
  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    IDLE = 3'd4
  } state_t;

  state_t           state;
  logic             brom_lat;
  logic             halt_pending;
  logic [CNT_W-1:0] wait_cnt;

  state_t           state_next;
  logic             brom_next;
  logic             halt_next;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       op_next;
  logic [3:0]       ack_next;
  logic             terr_next;
  logic             in_stage;
  logic [1:0]       idx;
  logic             advance;

  function automatic logic [1:0] selector_for(input state_t st, input logic [7:0] op,
                                              input logic brom);
    logic [1:0] sel;
    case (st)
      S0:      sel = {1'b0, brom};
      S1:      sel = op[1:0];
      S2:      sel = op[3:2];
      S3:      sel = op[5:4];
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  assign in_stage  = (state != IDLE);
  assign idx       = state[1:0];
  assign mem_valid = in_stage & stage_req[idx];

  // Next-state, handshake, timeout and halt bookkeeping.
  always_comb begin
    state_next = state;
    brom_next  = brom_lat;
    halt_next  = halt_pending;
    cnt_next   = wait_cnt;
    op_next    = instruction_op;
    ack_next   = 4'b0000;
    terr_next  = timeout_err;
    advance    = 1'b0;
    if (!in_stage) begin
      if (start) begin
        state_next = S0;
        brom_next  = execute_from_brom;
        cnt_next   = {CNT_W{1'b0}};
        terr_next  = 1'b0;
        halt_next  = halt;
      end else begin
        state_next = IDLE;
      end
    end else begin
      if (halt) begin
        halt_next = 1'b1;
      end else begin
        halt_next = halt_pending;
      end
      if (!stage_req[idx]) begin
        advance = 1'b1;
      end else if (mem_ready) begin
        advance  = 1'b1;
        ack_next = 4'b0001 << idx;
        if (state == S0) begin
          op_next = mem_rdata;
        end else begin
          op_next = instruction_op;
        end
      end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
        state_next = IDLE;
        terr_next  = 1'b1;
        halt_next  = 1'b0;
      end else begin
        cnt_next = wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (advance) begin
        cnt_next = {CNT_W{1'b0}};
        case (state)
          S0:      state_next = S1;
          S1:      state_next = S2;
          S2:      state_next = S3;
          S3: begin
            // A halt seen on the final cycle still ends the run here.
            if (halt_pending || halt) begin
              state_next = IDLE;
              halt_next  = 1'b0;
            end else begin
              state_next = S0;
              brom_next  = execute_from_brom;
            end
          end
          default: state_next = IDLE;
        endcase
      end else begin
        state_next = state_next;
      end
    end
  end

  // Register state and all derived outputs from the next-state values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      brom_lat        <= 1'b0;
      halt_pending    <= 1'b0;
      wait_cnt        <= {CNT_W{1'b0}};
      instruction_op  <= 8'h00;
      stage_ack       <= 4'b0000;
      timeout_err     <= 1'b0;
      grant           <= 2'b00;
      mblock_selector <= 2'b00;
      busy            <= 1'b0;
    end else begin
      state           <= state_next;
      brom_lat        <= brom_next;
      halt_pending    <= halt_next;
      wait_cnt        <= cnt_next;
      instruction_op  <= op_next;
      stage_ack       <= ack_next;
      timeout_err     <= terr_next;
      grant           <= (state_next == IDLE) ? 2'b00 : state_next[1:0];
      mblock_selector <= selector_for(state_next, op_next, brom_next);
      busy            <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/mblock_stage_sequencer.md
Name: mblock_stage_sequencer

Overview:
Sequences the shared memory block across the four instruction stages.
- Stage 0 fetches the instruction. Stages 1-3 perform operand and result accesses.
- Drives the port index (grant) and the mblock_selector consumed by the memory-block mux, and performs a valid/ready handshake with the memory block.
- Owns the stage-0 instruction-op latch, so later stages take their selector from the fetched opcode.

Parameters:
TIMEOUT, 16, max cycles mem_valid may stay high without mem_ready before abort (>=2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  input  1  clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset, sampled on posedge clk
start  input  1  begin instruction execution from IDLE
halt  input  1  stop after current instruction completes
execute_from_brom  input  1  stage-0 source is boot ROM
stage_req  input  4  bit k: stage k needs memory this instruction
mem_ready  input  1  memory block accepts/completes access
mem_rdata  input  8  memory read data (stage-0 opcode byte)
grant  output  2  active stage/port index to mux (0..3)
mblock_selector  output  2  memory block selector for active stage
mem_valid  output  1  access request to memory block
stage_ack  output  4  one-cycle pulse, bit k = stage k access completed
instruction_op  output  8  latched opcode from stage 0
busy  output  1  sequencer not IDLE
timeout_err  output  1  sticky abort flag

Behaviour:
- States: IDLE, S0, S1, S2, S3. grant = stage number in Sk, 0 in IDLE.
- Reset (reset_n=0 at posedge), from any state including mid-handshake, all outputs zero by the next edge:
  - state=IDLE, grant=0, mblock_selector=0, mem_valid=0, stage_ack=0, instruction_op=0, busy=0, timeout_err=0.
  - halt_pending=0, wait counter=0.
- IDLE:
  - start=1 -> S0 next cycle, and timeout_err clears.
  - start ignored while busy=1.
- Entry to any Sk: wait counter cleared.
- Entry to S0: brom_lat<=execute_from_brom.
- mblock_selector:
  - S0: {1'b0, brom_lat}.
  - S1: instruction_op[1:0]. S2: instruction_op[3:2]. S3: instruction_op[5:4].
- mem_valid = (state==Sk) & stage_req[k], decoded combinationally from the registered state.
- Handshake: mem_valid & mem_ready at a posedge completes the access:
  - stage_ack[k]=1 for exactly the following cycle.
  - The state advances to the next stage on that edge.
  - Latency: best case 1 cycle per requested stage.
  - In S0 the same edge loads instruction_op<=mem_rdata.
- Skip: stage_req[k]=0 while in Sk -> advance next edge, no ack, mem_valid stays 0. A fully skipped instruction takes 4 cycles.
- stage_req is sampled every cycle in Sk. Dropping it while waiting converts the wait to a skip.
- Wait timeout:
  - Counter increments each cycle mem_valid=1 & mem_ready=0.
  - If it reaches TIMEOUT-1 with mem_ready still 0, the next edge goes to IDLE and sets timeout_err=1.
  - No ack is issued. halt_pending clears.
- Sequence: S0->S1->S2->S3. After S3 completes (ack or skip):
  - S0 if halt_pending=0.
  - Otherwise IDLE, and halt_pending clears.
- halt:
  - halt=1 in any non-IDLE cycle sets halt_pending.
  - halt and start together in IDLE: start wins, halt_pending set, exactly one instruction runs.
  - halt alone in IDLE: no effect.
- busy=1 in S0..S3.
- stage_ack is never more than one-hot.

Test Plan:
1. Reset then start, stage_req=4'b1111, mem_ready=1 constantly, mem_rdata=8'h39 in S0 -> mem_valid high 4 consecutive cycles, grant 0,1,2,3, stage_ack 0001,0010,0100,1000, instruction_op=8'h39, selectors S1=01, S2=10, S3=11.
2. start with execute_from_brom=1, stage_req=4'b0101, mem_ready=1 -> S0 selector=01, S1 and S3 skipped (mem_valid=0, no ack), one instruction = 4 cycles.
3. stage_req=4'b0001, mem_ready held low 5 cycles then high -> mem_valid high 6 cycles in S0, single stage_ack[0] pulse on cycle 7, no timeout.
4. TIMEOUT=16, mem_ready never asserted in S1 -> after 16 cycles of mem_valid: IDLE, timeout_err=1, busy=0. Next start clears timeout_err.
5. halt pulsed during S1 of the first instruction -> S3 completes, IDLE, busy=0, no further S0. start+halt together in IDLE -> exactly one instruction, then IDLE.
6. reset_n=0 mid-wait in S2 with mem_valid=1 -> next edge all outputs zero, state IDLE. start then resumes from S0.
